nand_gate_16: RTL and testbench



---
 rtl/nand_gate_16.sv | 120 ++++++++++++
 tb/tb_nand_gate_16.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/nand_gate_16.sv
// nand_gate_16
//   Registered 16-bit bitwise NAND slice for the ALU logic-op group.
//   Operands sampled with in_valid produce ~(in1 & in2) on the next edge.
//
// Build option:
//   NAND_GATE_16_FLAGS_EN  defined   -> zero / all_ones / popcnt registers built
//                          undefined -> those ports tied to 0, no flag flops
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in1, in2   in   [WIDTH-1:0] operands
//   in_valid   in   operands valid this cycle
//   out        out  [WIDTH-1:0] registered NAND result
//   out_valid  out  out was loaded on the last edge
//   zero       out  registered result == 0        (flags build)
//   all_ones   out  registered result == all ones (flags build)
//   popcnt     out  [4:0] registered count of ones in result (flags build)

module nand_gate_16 #(
    parameter int WIDTH = 16   // only 16 is supported
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             zero,
    output logic             all_ones,
    output logic [4:0]       popcnt
);

    logic [WIDTH-1:0] nand_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             out_valid_q;
    logic             out_valid_d;

    assign nand_d = ~(in1 & in2);

    always_comb begin
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            out_d       = nand_d;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

`ifdef NAND_GATE_16_FLAGS_EN

    function automatic logic [4:0] count_ones(input logic [WIDTH-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + {4'b0000, v[i]};
        end
        return c;
    endfunction

    logic       zero_q;
    logic       zero_d;
    logic       all_ones_q;
    logic       all_ones_d;
    logic [4:0] popcnt_q;
    logic [4:0] popcnt_d;

    // Flags are derived from the incoming result, not from out_q, so they
    // land on the same edge as the result they describe.
    always_comb begin
        zero_d     = zero_q;
        all_ones_d = all_ones_q;
        popcnt_d   = popcnt_q;
        if (in_valid) begin
            zero_d     = (nand_d == '0);
            all_ones_d = (nand_d == '1);
            popcnt_d   = count_ones(nand_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_q     <= 1'b0;
            all_ones_q <= 1'b0;
            popcnt_q   <= '0;
        end else begin
            zero_q     <= zero_d;
            all_ones_q <= all_ones_d;
            popcnt_q   <= popcnt_d;
        end
    end

    assign zero     = zero_q;
    assign all_ones = all_ones_q;
    assign popcnt   = popcnt_q;

`else

    assign zero     = 1'b0;
    assign all_ones = 1'b0;
    assign popcnt   = 5'd0;

`endif

endmodule

// File: tb/tb_nand_gate_16.sv
module tb_nand_gate_16;

    logic        clk;
    logic        rst_n;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        in_valid;
    logic [15:0] out;
    logic        out_valid;
    logic        zero;
    logic        all_ones;
    logic [4:0]  popcnt;

    int total;
    int bad;

    // reference flag state (tracks what the flag registers should hold)
    logic       m_zero;
    logic       m_ones;
    logic [4:0] m_pc;

    nand_gate_16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in1       (in1),
        .in2       (in2),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid),
        .zero      (zero),
        .all_ones  (all_ones),
        .popcnt    (popcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;      // 1 = assert reset (rst_n low) this cycle
        logic [15:0] a;
        logic [15:0] b;
        logic        v;
        logic [15:0] exp_out;
        logic        exp_ov;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Update the flag reference for one edge.
    task automatic model_edge(input logic rst, input logic v, input logic [15:0] res);
        if (rst) begin
            m_zero = 1'b0;
            m_ones = 1'b0;
            m_pc   = 5'd0;
        end else if (v) begin
            m_zero = (res == 16'h0000);
            m_ones = (res == 16'hFFFF);
            m_pc   = 5'($countones(res));
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] exp_out, input logic exp_ov);
        chk({tag, ".out"}, out, exp_out);
        chk({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, exp_ov});
`ifdef NAND_GATE_16_FLAGS_EN
        chk({tag, ".zero"}, {15'd0, zero}, {15'd0, m_zero});
        chk({tag, ".all_ones"}, {15'd0, all_ones}, {15'd0, m_ones});
        chk({tag, ".popcnt"}, {11'd0, popcnt}, {11'd0, m_pc});
`else
        chk({tag, ".zero"}, {15'd0, zero}, 16'd0);
        chk({tag, ".all_ones"}, {15'd0, all_ones}, 16'd0);
        chk({tag, ".popcnt"}, {11'd0, popcnt}, 16'd0);
`endif
    endtask

    // Drive one cycle of inputs, take the edge, sample 1 ns later.
    task automatic apply(input logic rst, input logic [15:0] a, input logic [15:0] b,
                         input logic v);
        rst_n    = ~rst;
        in1      = a;
        in2      = b;
        in_valid = v;
        @(posedge clk);
        #1;
        model_edge(rst, v, ~(a & b));
    endtask

    vec_t vecs[12];

    initial begin
        total    = 0;
        bad      = 0;
        m_zero   = 1'b0;
        m_ones   = 1'b0;
        m_pc     = 5'd0;
        rst_n    = 1'b0;
        in1      = '0;
        in2      = '0;
        in_valid = 1'b0;

        //           rst   a         b         v     exp_out   exp_ov
        vecs[0]  = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b0}; // capture in reset dropped
        vecs[1]  = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1}; // zero=1
        vecs[2]  = '{1'b0, 16'h0000, 16'h1234, 1'b1, 16'hFFFF, 1'b1}; // all_ones, pc=16
        vecs[3]  = '{1'b0, 16'hA5A5, 16'h0F0F, 1'b1, 16'hFAFA, 1'b1}; // pc=12
        vecs[4]  = '{1'b0, 16'h0000, 16'h0F0F, 1'b0, 16'hFAFA, 1'b0}; // hold
        vecs[5]  = '{1'b0, 16'h1234, 16'h5678, 1'b0, 16'hFAFA, 1'b0}; // operand change ignored
        vecs[6]  = '{1'b1, 16'h1234, 16'hFFFF, 1'b1, 16'h0000, 1'b0}; // reset beats valid
        vecs[7]  = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0}; // zero stays 0 after reset
        vecs[8]  = '{1'b0, 16'h00FF, 16'hFF00, 1'b1, 16'hFFFF, 1'b1};
        vecs[9]  = '{1'b0, 16'hF0F0, 16'hFFFF, 1'b1, 16'h0F0F, 1'b1}; // pc=8
        vecs[10] = '{1'b0, 16'h8001, 16'h8001, 1'b1, 16'h7FFE, 1'b1}; // pc=14
        vecs[11] = '{1'b0, 16'hFFFE, 16'hFFFF, 1'b1, 16'h0001, 1'b1}; // pc=1

        // reset state
        apply(1'b1, 16'h0000, 16'h0000, 1'b0);
        apply(1'b1, 16'h0000, 16'h0000, 1'b0);
        chk_all("reset", 16'h0000, 1'b0);

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].v);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_ov);
        end

        // back-to-back random operands, fresh result every edge
        for (int i = 0; i < 20; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 3) rb = ra;   // force some overlap-heavy patterns
            apply(1'b0, ra, rb, 1'b1);
            chk_all($sformatf("rnd%0d", i), ~(ra & rb), 1'b1);
        end

        // valid dropped after the random burst: result holds, out_valid falls
        begin
            logic [15:0] last;
            last = out;
            apply(1'b0, 16'h0000, 16'h0000, 1'b0);
            chk_all("tail_hold", last, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
